// File: rtl/cp0_unit.sv
// Coprocessor-0 status/cause/EPC registers and exception/interrupt request for the M stage.
// Latency: req is combinational from M inputs and current SR; register updates are visible one cycle after the edge.
// Backpressure: none. req flushes the pipeline. While EXL=1 further requests are masked until eret clears EXL.
module cp0_unit #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exccode_in,
    input  logic        exl_clr,
    input  logic [5:0]  hwint,
    output logic        req,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;

    // SR fields
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    // Cause fields
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exccode;
    // EPC
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Request generation: EXL masks both interrupts and exceptions so handlers cannot nest.
    always_comb begin
        int_req = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
        exc_req = (exccode_in != 5'd0) & ~sr_exl;
        req     = int_req | exc_req;
    end

    // Register state: reset > taken request > eret > mtc0. IP tracks the lines every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im         <= 6'd0;
            sr_exl        <= 1'b0;
            sr_ie         <= 1'b0;
            cause_bd      <= 1'b0;
            cause_ip      <= 6'd0;
            cause_exccode <= 5'd0;
            epc           <= 32'd0;
        end else begin
            cause_ip <= hwint;
            if (req) begin
                // The faulting or interrupted instruction does not commit, so its mtc0 is dropped.
                sr_exl        <= 1'b1;
                cause_bd      <= bd_m;
                epc           <= bd_m ? (pc_m - 32'd4) : pc_m;
                cause_exccode <= int_req ? 5'd0 : exccode_in;
            end else begin
                if (en) begin
                    if (cp0_addr == ADDR_SR) begin
                        sr_im  <= cp0_wdata[15:10];
                        sr_exl <= cp0_wdata[1];
                        sr_ie  <= cp0_wdata[0];
                    end else if (cp0_addr == ADDR_EPC) begin
                        epc <= cp0_wdata;
                    end
                end
                // eret wins over a same-cycle SR write to EXL.
                if (exl_clr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    // Read mux over current register values; unimplemented addresses read as zero.
    always_comb begin
        sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
        cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exccode, 2'd0};
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = sr_word;
            ADDR_CAUSE: cp0_rdata = cause_word;
            ADDR_EPC:   cp0_rdata = epc;
            default:    cp0_rdata = 32'd0;
        endcase
    end

    assign epc_out    = epc;
    assign handler_pc = HANDLER_PC;

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline, placed at the M stage. It consumes the exception code, PC and branch-delay flag carried down the pipeline registers, plus external hardware interrupt lines. It raises `req`, which flushes every pipeline register and redirects fetch to 0x0000_4180. It also holds SR/Cause/EPC for `mfc0`/`mtc0`/`eret`.

## Interface
- `HANDLER_PC` (default 32'h0000_4180): handler entry address, exported for fetch redirect.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  `mtc0` write enable from the M stage.
- `cp0_addr`  in  5  register number for read/write (12 = SR, 13 = Cause, 14 = EPC).
- `cp0_wdata`  in  32  `mtc0` write data.
- `pc_m`  in  32  PC of the instruction in M.
- `bd_m`  in  1  M instruction sits in a branch delay slot.
- `exccode_in`  in  5  exception code of the M instruction; 0 means none.
- `exl_clr`  in  1  `eret` in M; clears EXL.
- `hwint`  in  6  external interrupt lines, level-sensitive.
- `req`  out  1  exception/interrupt taken this cycle (combinational).
- `cp0_rdata`  out  32  combinational read of `cp0_addr`.
- `epc_out`  out  32  current EPC register, used as the `eret` target.
- `handler_pc`  out  32  constant `HANDLER_PC`.

## Operation
- **SR (12)**
  - Implemented bits: IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
  - `mtc0` writes only the implemented bits.
- **Cause (13)**
  - Fields: BD = [31], IP = [15:10], ExcCode = [6:2]; other bits read 0.
  - Software-read-only: `mtc0` to 13 is ignored.
- **EPC (14)**: full 32 bits, writable by `mtc0`.
- **Request logic**
  - `int_req` = |(`hwint` & IM) & IE & ~EXL.
  - `exc_req` = (`exccode_in` != 0) & ~EXL.
  - `req` = `int_req` | `exc_req`.
- **On an edge with `req`=1**
  - EXL <= 1.
  - BD <= `bd_m`.
  - EPC <= `bd_m` ? `pc_m`-4 : `pc_m` (32-bit wrap).
  - ExcCode <= `int_req` ? 0 : `exccode_in`. Interrupt has priority over a synchronous exception.
- **Priority at one edge**: `req` > `exl_clr` > `mtc0` write. A `mtc0` is suppressed when `req`=1, because the faulting or interrupted instruction must not commit.
- **`exl_clr`**: EXL <= 0 on the edge. If `en` targets SR in the same cycle, the write applies first and EXL is then forced to 0.
- **IP**: IP <= `hwint` on every edge, unconditionally, including while EXL=1.
- **Read**: `cp0_rdata` is a mux on `cp0_addr` over the current register values; unimplemented addresses return 0. There is no write-to-read bypass inside the block; the pipeline's hazard unit owns `mtc0`→`mfc0`/`eret` ordering.
- **Nesting**: while EXL=1, `req` stays 0 and EPC/Cause.BD/ExcCode hold.

## Timing
- `req` is combinational from same-cycle M inputs and current SR. The pipeline registers sample it at the same edge at which CP0 updates EXL/EPC/Cause.
- Register updates have 1-cycle latency; `cp0_rdata`/`epc_out` show new values the cycle after the edge.
- **Reset**
  - SR, Cause and EPC are 0.
  - Hence `req`=0, `cp0_rdata`=0, `epc_out`=0.
  - `reset` dominates `req`, `exl_clr` and `en` at the same edge.
- Because EXL=1 immediately after a taken request, `req` can be high for at most one cycle per event. It re-arms only after `eret` clears EXL.
- `hwint` held high with IE=1 and EXL=0 re-raises `req` the cycle after `eret`; this is intended.

## Test plan
1. **Reset**: reset 1 cycle → SR=Cause=EPC=0, `req`=0; `hwint`=6'h3F alone → `req` stays 0 (IM=0).
2. **Synchronous exception**
   - Stimulus: `exccode_in`=5'd10, `pc_m`=32'h3010, `bd_m`=0.
   - Response: `req`=1 same cycle; next cycle EPC=32'h3010, Cause.ExcCode=10, BD=0, SR.EXL=1, `req`=0.
3. **Delay-slot exception**: `exccode_in`=4, `pc_m`=32'h3024, `bd_m`=1 → EPC=32'h3020, Cause=32'h8000_0010.
4. **Interrupt beats exception**
   - Setup: `mtc0` SR←32'h0000_0401 (IM[10]=1, IE=1).
   - Stimulus: `hwint`=6'b000001 with `exccode_in`=12.
   - Response: ExcCode=0, Cause.IP[10]=1.
   - A simultaneous `mtc0` EPC←32'hDEAD is dropped; EPC = `pc_m`.
5. **`eret` and re-arm**
   - While EXL=1: `hwint` asserted → `req`=0.
   - `exl_clr` pulse → EXL=0; `req`=1 the following cycle if `hwint` is still high.
6. **Register access**
   - `mtc0` Cause←32'hFFFF_FFFF → Cause unchanged.
   - `mtc0` SR←32'hFFFF_FFFF → SR reads 32'h0000_FC03.
   - Read `cp0_addr`=7 → 0.
